// File: rtl/input_conditioner_pkg.sv
// rtl/input_conditioner_pkg.sv - shared types and sizing helper for the input conditioner
package input_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    // Counter width wide enough to hold (max(a, b) - 1); never narrower than 1 bit.
    function automatic int cnt_width(input int a, input int b);
        int wa;
        int wb;
        int w;
        wa = $clog2(a);
        wb = $clog2(b);
        w  = (wa > wb) ? wa : wb;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/input_conditioner_ch.sv
// rtl/input_conditioner_ch.sv - one channel: synchroniser, debounce, edge pulses, auto-repeat
module input_conditioner_ch
    import input_conditioner_pkg::*;
#(
    parameter int ACTIVE_LOW    = 1,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 500000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_RATE   = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    input  logic i_repeat_en,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);

    localparam int DW = cnt_width(STABLE_CYCLES, STABLE_CYCLES);
    localparam int RW = cnt_width(REPEAT_DELAY, REPEAT_RATE);

    localparam logic [DW-1:0] STABLE_LAST = DW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST   = RW'(REPEAT_RATE - 1);

    logic                   pressed_raw;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    logic [DW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise, fall;

    rpt_state_t    state_q, state_d;
    logic [RW-1:0] r_q, r_d;
    logic          repeat_d;

    logic press_q, release_q, repeat_q;

    // Polarity is normalised before synchronising so every flop resets to "not pressed" = 0.
    assign pressed_raw = i_raw ^ (ACTIVE_LOW != 0);
    assign s           = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pressed_raw};
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise    = 1'b0;
        fall    = 1'b0;
        if (s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == STABLE_LAST) begin
            level_d = s;
            cnt_d   = '0;
            rise    = s;
            fall    = ~s;
        end else begin
            cnt_d = cnt_q + DW'(1);
        end
    end

    // A release or a dropped enable wins over an expiring count: no pulse on exit.
    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        repeat_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    repeat_d = 1'b1;
                    if (i_repeat_en) begin
                        state_d = DELAY;
                        r_d     = '0;
                    end
                end
            end
            DELAY: begin
                if (fall || !i_repeat_en) begin
                    state_d = IDLE;
                    r_d     = '0;
                end else if (r_q == DELAY_LAST) begin
                    repeat_d = 1'b1;
                    state_d  = REPEAT;
                    r_d      = '0;
                end else begin
                    r_d = r_q + RW'(1);
                end
            end
            REPEAT: begin
                if (fall || !i_repeat_en) begin
                    state_d = IDLE;
                    r_d     = '0;
                end else if (r_q == RATE_LAST) begin
                    repeat_d = 1'b1;
                    r_d      = '0;
                end else begin
                    r_d = r_q + RW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                r_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            state_q   <= IDLE;
            r_q       <= '0;
        end else begin
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= rise;
            release_q <= fall;
            repeat_q  <= repeat_d;
            state_q   <= state_d;
            r_q       <= r_d;
        end
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_repeat  = repeat_q;

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - multi-channel button/joystick front end, one independent channel per input
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int NUM_CH        = 5,
    parameter int ACTIVE_LOW    = 1,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 500000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_RATE   = 5000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] i_raw,
    input  logic [NUM_CH-1:0] i_repeat_en,
    output logic [NUM_CH-1:0] o_level,
    output logic [NUM_CH-1:0] o_press,
    output logic [NUM_CH-1:0] o_release,
    output logic [NUM_CH-1:0] o_repeat
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        input_conditioner_ch #(
            .ACTIVE_LOW    (ACTIVE_LOW),
            .SYNC_STAGES   (SYNC_STAGES),
            .STABLE_CYCLES (STABLE_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_RATE   (REPEAT_RATE)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_raw       (i_raw[g]),
            .i_repeat_en (i_repeat_en[g]),
            .o_level     (o_level[g]),
            .o_press     (o_press[g]),
            .o_release   (o_release[g]),
            .o_repeat    (o_repeat[g])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - self-checking bench for input_conditioner
module tb_input_conditioner;

    localparam int NUM_CH        = 5;
    localparam int ACTIVE_LOW    = 1;
    localparam int SYNC_STAGES   = 2;
    localparam int STABLE_CYCLES = 4;
    localparam int REPEAT_DELAY  = 10;
    localparam int REPEAT_RATE   = 3;

    logic              clk;
    logic              rst_n;
    logic [NUM_CH-1:0] i_raw;
    logic [NUM_CH-1:0] i_repeat_en;
    logic [NUM_CH-1:0] o_level;
    logic [NUM_CH-1:0] o_press;
    logic [NUM_CH-1:0] o_release;
    logic [NUM_CH-1:0] o_repeat;

    int n_chk  = 0;
    int n_fail = 0;

    input_conditioner #(
        .NUM_CH        (NUM_CH),
        .ACTIVE_LOW    (ACTIVE_LOW),
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_RATE   (REPEAT_RATE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_raw       (i_raw),
        .i_repeat_en (i_repeat_en),
        .o_level     (o_level),
        .o_press     (o_press),
        .o_release   (o_release),
        .o_repeat    (o_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: pressed samples delayed by the synchroniser, a run-length of disagreeing
    // samples, and a timestamp of the next scheduled repeat pulse.
    bit m_pipe [NUM_CH][SYNC_STAGES];
    int m_run  [NUM_CH];
    bit m_lvl  [NUM_CH];
    bit m_prs  [NUM_CH];
    bit m_rel  [NUM_CH];
    bit m_rpt  [NUM_CH];
    bit m_act  [NUM_CH];
    int m_next [NUM_CH];
    int m_t;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t = 0;
            for (int c = 0; c < NUM_CH; c++) begin
                for (int k = 0; k < SYNC_STAGES; k++) m_pipe[c][k] = 1'b0;
                m_run[c] = 0;
                m_lvl[c] = 1'b0;
                m_prs[c] = 1'b0;
                m_rel[c] = 1'b0;
                m_rpt[c] = 1'b0;
                m_act[c] = 1'b0;
                m_next[c] = 0;
            end
        end else begin
            m_t = m_t + 1;
            for (int c = 0; c < NUM_CH; c++) begin
                bit s;
                bit rise;
                bit fall;
                s = m_pipe[c][SYNC_STAGES-1];
                for (int k = SYNC_STAGES - 1; k > 0; k--) m_pipe[c][k] = m_pipe[c][k-1];
                m_pipe[c][0] = i_raw[c] ^ (ACTIVE_LOW != 0);
                rise = 1'b0;
                fall = 1'b0;
                if (s != m_lvl[c]) begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] == STABLE_CYCLES) begin
                        m_lvl[c] = s;
                        m_run[c] = 0;
                        rise = s;
                        fall = !s;
                    end
                end else begin
                    m_run[c] = 0;
                end
                m_prs[c] = rise;
                m_rel[c] = fall;
                m_rpt[c] = 1'b0;
                if (rise) begin
                    m_rpt[c]  = 1'b1;
                    m_act[c]  = i_repeat_en[c];
                    m_next[c] = m_t + REPEAT_DELAY;
                end else if (m_act[c]) begin
                    if (fall || !i_repeat_en[c]) begin
                        m_act[c] = 1'b0;
                    end else if (m_t == m_next[c]) begin
                        m_rpt[c]  = 1'b1;
                        m_next[c] = m_t + REPEAT_RATE;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [NUM_CH-1:0] e_lvl, e_prs, e_rel, e_rpt;
        for (int c = 0; c < NUM_CH; c++) begin
            e_lvl[c] = m_lvl[c];
            e_prs[c] = m_prs[c];
            e_rel[c] = m_rel[c];
            e_rpt[c] = m_rpt[c];
        end
        n_chk = n_chk + 4;
        if (o_level !== e_lvl) begin
            n_fail++;
            $display("FAIL model_level t=%0t: got %b expected %b", $time, o_level, e_lvl);
        end
        if (o_press !== e_prs) begin
            n_fail++;
            $display("FAIL model_press t=%0t: got %b expected %b", $time, o_press, e_prs);
        end
        if (o_release !== e_rel) begin
            n_fail++;
            $display("FAIL model_release t=%0t: got %b expected %b", $time, o_release, e_rel);
        end
        if (o_repeat !== e_rpt) begin
            n_fail++;
            $display("FAIL model_repeat t=%0t: got %b expected %b", $time, o_repeat, e_rpt);
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        i_raw       = '1;
        i_repeat_en = '0;
        edges(3);
        chk("reset_level", int'(o_level), 0);
        chk("reset_press", int'(o_press), 0);
        chk("reset_repeat", int'(o_repeat), 0);
        rst_n = 1'b1;
        edges(3);

        // 1: clean press on ch0, no auto-repeat
        i_raw[0] = 1'b0;
        edges(5);
        chk("t1_level_e5", int'(o_level[0]), 0);
        edges(1);
        chk("t1_level_e6", int'(o_level[0]), 1);
        chk("t1_press_e6", int'(o_press[0]), 1);
        chk("t1_repeat_e6", int'(o_repeat[0]), 1);
        edges(1);
        chk("t1_press_e7", int'(o_press[0]), 0);
        chk("t1_repeat_e7", int'(o_repeat[0]), 0);
        edges(50);
        chk("t1_level_held", int'(o_level[0]), 1);
        i_raw[0] = 1'b1;
        edges(6);
        chk("t1_release", int'(o_release[0]), 1);
        chk("t1_level_rel", int'(o_level[0]), 0);
        edges(4);

        // 2: glitches shorter than the debounce window on ch1
        repeat (5) begin
            i_raw[1] = 1'b0;
            edges(3);
            i_raw[1] = 1'b1;
            edges(3);
        end
        edges(6);
        chk("t2_level", int'(o_level[1]), 0);

        // 3: auto-repeat on ch2, release suppresses the coinciding tick
        i_repeat_en[2] = 1'b1;
        i_raw[2]       = 1'b0;
        edges(6);
        chk("t3_press_e6", int'(o_press[2]), 1);
        chk("t3_repeat_e6", int'(o_repeat[2]), 1);
        edges(9);
        chk("t3_repeat_e15", int'(o_repeat[2]), 0);
        edges(1);
        chk("t3_repeat_e16", int'(o_repeat[2]), 1);
        edges(3);
        chk("t3_repeat_e19", int'(o_repeat[2]), 1);
        edges(6);
        chk("t3_repeat_e25", int'(o_repeat[2]), 1);
        i_raw[2] = 1'b1;
        edges(3);
        chk("t3_repeat_e28", int'(o_repeat[2]), 1);
        edges(3);
        chk("t3_repeat_e31", int'(o_repeat[2]), 0);
        chk("t3_release_e31", int'(o_release[2]), 1);
        chk("t3_level_e31", int'(o_level[2]), 0);
        i_repeat_en[2] = 1'b0;
        edges(10);

        // 4: repeat enable dropped while held on ch3
        i_repeat_en[3] = 1'b1;
        i_raw[3]       = 1'b0;
        edges(16);
        chk("t4_repeat_e16", int'(o_repeat[3]), 1);
        i_repeat_en[3] = 1'b0;
        edges(3);
        chk("t4_repeat_e19", int'(o_repeat[3]), 0);
        chk("t4_level_e19", int'(o_level[3]), 1);
        edges(10);
        i_raw[3] = 1'b1;
        edges(8);

        // 5: reset in the middle of a hold on ch4
        i_raw[4] = 1'b0;
        edges(11);
        chk("t5_level_pre", int'(o_level[4]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_level_async", int'(o_level), 0);
        chk("t5_press_async", int'(o_press), 0);
        chk("t5_repeat_async", int'(o_repeat), 0);
        edges(2);
        rst_n = 1'b1;
        edges(5);
        chk("t5_press_e5", int'(o_press[4]), 0);
        edges(1);
        chk("t5_press_e6", int'(o_press[4]), 1);
        chk("t5_level_e6", int'(o_level[4]), 1);
        i_raw[4] = 1'b1;
        edges(8);

        // 6: staggered presses on ch0 and ch4
        i_raw[0] = 1'b0;
        edges(2);
        i_raw[4] = 1'b0;
        edges(4);
        chk("t6_press0_e6", int'(o_press[0]), 1);
        chk("t6_press4_e6", int'(o_press[4]), 0);
        edges(2);
        chk("t6_press0_e8", int'(o_press[0]), 0);
        chk("t6_press4_e8", int'(o_press[4]), 1);
        chk("t6_others", int'(o_level[3:1]), 0);
        edges(5);
        i_raw[0] = 1'b1;
        i_raw[4] = 1'b1;
        edges(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
